imm_gen_pipe: RTL and testbench

//  Parametrised, pipelined immediate generator for the single-cycle/pipelined CPU datapath.

---
 rtl/imm_pkg.sv | 18 +
 rtl/imm_extract.sv | 38 +++
 rtl/imm_gen_pipe.sv | 89 ++++++++
 tb/tb_imm_gen_pipe.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared constants for the pipelined immediate generator: instruction format codes and default widths.
package imm_pkg;

    localparam int unsigned FMT_W     = 3;
    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned ILEN_DEF  = 32;
    localparam int unsigned CNT_W_DEF = 16;

    localparam logic [FMT_W-1:0] FMT_I     = 3'd0;
    localparam logic [FMT_W-1:0] FMT_S     = 3'd1;
    localparam logic [FMT_W-1:0] FMT_B     = 3'd2;
    localparam logic [FMT_W-1:0] FMT_U     = 3'd3;
    localparam logic [FMT_W-1:0] FMT_J     = 3'd4;
    localparam logic [FMT_W-1:0] FMT_SHAMT = 3'd5;
    localparam logic [FMT_W-1:0] FMT_ZI    = 3'd6;
    localparam logic [FMT_W-1:0] FMT_RSV   = 3'd7;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction and extension for the RV32 instruction field layout.
module imm_extract
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned ILEN = ILEN_DEF
) (
    input  logic [ILEN-1:0]  i_instr,
    input  logic [FMT_W-1:0] i_fmt,
    output logic [XLEN-1:0]  o_imm,
    output logic             o_err
);

    // Opcode bits never contribute to an immediate.
    logic [6:0] w_unused_opcode;
    assign w_unused_opcode = i_instr[6:0];

    always_comb begin
        o_imm = '0;
        o_err = 1'b0;
        unique case (i_fmt)
            FMT_I:     o_imm = XLEN'($signed(i_instr[31:20]));
            FMT_S:     o_imm = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
            FMT_B:     o_imm = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25],
                                              i_instr[11:8], 1'b0}));
            FMT_U:     o_imm = XLEN'($signed({i_instr[31:12], 12'b0}));
            FMT_J:     o_imm = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20],
                                              i_instr[30:21], 1'b0}));
            FMT_SHAMT: o_imm = XLEN'(i_instr[24:20]);
            FMT_ZI:    o_imm = XLEN'(i_instr[31:20]);
            default: begin
                o_imm = '0;
                o_err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: registered output stage plus a one-entry skid buffer,
// valid/ready on both sides, and a counter of accepted input transfers.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned ILEN  = ILEN_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ILEN-1:0]  in_instr,
    input  logic [FMT_W-1:0] in_fmt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_err,
    output logic [CNT_W-1:0] acc_cnt
);

    logic [XLEN-1:0]  w_imm;
    logic             w_err;
    logic             w_in_fire;
    logic             w_out_load;

    logic             r_out_valid;
    logic [XLEN-1:0]  r_out_imm;
    logic             r_out_err;
    logic             r_skid_valid;
    logic [XLEN-1:0]  r_skid_imm;
    logic             r_skid_err;
    logic [CNT_W-1:0] r_acc_cnt;

    imm_extract #(
        .XLEN (XLEN),
        .ILEN (ILEN)
    ) u_extract (
        .i_instr (in_instr),
        .i_fmt   (in_fmt),
        .o_imm   (w_imm),
        .o_err   (w_err)
    );

    // Ready depends only on skid occupancy; held low while reset is asserted.
    assign in_ready   = ~r_skid_valid & ~rst;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_load = ~r_out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_imm    <= '0;
            r_out_err    <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_imm   <= '0;
            r_skid_err   <= 1'b0;
            r_acc_cnt    <= '0;
        end else begin
            if (w_out_load) begin
                // A full skid blocks input, so it drains before any new item is taken.
                if (r_skid_valid) begin
                    r_out_valid  <= 1'b1;
                    r_out_imm    <= r_skid_imm;
                    r_out_err    <= r_skid_err;
                    r_skid_valid <= 1'b0;
                end else begin
                    r_out_valid <= w_in_fire;
                    if (w_in_fire) begin
                        r_out_imm <= w_imm;
                        r_out_err <= w_err;
                    end
                end
            end else if (w_in_fire) begin
                r_skid_valid <= 1'b1;
                r_skid_imm   <= w_imm;
                r_skid_err   <= w_err;
            end
            r_acc_cnt <= r_acc_cnt + CNT_W'(w_in_fire);
        end
    end

    assign out_valid = r_out_valid;
    assign out_imm   = r_out_imm;
    assign out_err   = r_out_err;
    assign acc_cnt   = r_acc_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: directed format vectors, backpressure, error format,
// mid-stream reset, and randomized traffic against a queue-based reference model.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [2:0]  in_fmt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic        out_err;
    logic [15:0] acc_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    imm_gen_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_fmt    (in_fmt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_err   (out_err),
        .acc_cnt   (acc_cnt)
    );

    always #5 clk = ~clk;

    // Reference: build the field value arithmetically, then apply the two's-complement weight of the sign bit.
    function automatic logic [32:0] ref_model(input logic [31:0] ins, input logic [2:0] fmt);
        longint v;
        logic   e;
        v = 0;
        e = 1'b0;
        case (fmt)
            3'd0: v = longint'(ins[31:20]) - (ins[31] ? 4096 : 0);
            3'd1: v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]) - (ins[31] ? 4096 : 0);
            3'd2: v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
                      + longint'(ins[11:8]) * 2 - (ins[31] ? 4096 : 0);
            3'd3: v = longint'(ins[31:12]) * 4096;
            3'd4: v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
                      + longint'(ins[30:21]) * 2 - (ins[31] ? 1048576 : 0);
            3'd5: v = longint'(ins[24:20]);
            3'd6: v = longint'(ins[31:20]);
            default: begin
                v = 0;
                e = 1'b1;
            end
        endcase
        return {e, 32'(v)};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_fmt    = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        n_cmp++;
        if (out_valid !== 1'b0 || out_err !== 1'b0 || out_imm !== 32'h0 || acc_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_state got v=%b e=%b imm=%h cnt=%0d want 0/0/0/0",
                     out_valid, out_err, out_imm, acc_cnt);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_formats();
        logic [31:0] v_ins [7] = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3, 32'h123450B7,
                                   32'h0010006F, 32'h01F09093, 32'hFFF00093};
        logic [2:0]  v_fmt [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
        logic [31:0] v_exp [7] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000,
                                   32'h00000800, 32'h0000001F, 32'h00000FFF};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_instr  = v_ins[i];
            in_fmt    = v_fmt[i];
            out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            in_instr = 'x;
            in_fmt   = 'x;
            n_cmp++;
            if (out_valid !== 1'b1 || out_imm !== v_exp[i] || out_err !== 1'b0) begin
                n_fail++;
                $display("FAIL fmt%0d_vector got v=%b imm=%h e=%b want 1/%h/0",
                         v_fmt[i], out_valid, out_imm, out_err, v_exp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ins [3] = '{32'h00100093, 32'h00200093, 32'h80000093};
        logic [31:0] exp_imm [3] = '{32'h00000001, 32'h00000002, 32'hFFFFF800};
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_fmt    = 3'd0;
        in_instr  = ins[0];
        @(negedge clk);
        in_instr = ins[1];
        @(negedge clk);
        in_instr = ins[2];
        #1;
        n_cmp++;
        if (in_ready !== 1'b0 || acc_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL bp_stall got rdy=%b cnt=%0d want 0/2", in_ready, acc_cnt);
        end
        n_cmp++;
        if (out_valid !== 1'b1 || out_imm !== exp_imm[0]) begin
            n_fail++;
            $display("FAIL bp_hold got v=%b imm=%h want 1/%h", out_valid, out_imm, exp_imm[0]);
        end
        out_ready = 1'b1;
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            if (k == 2) in_valid = 1'b0;
            n_cmp++;
            if (out_valid !== 1'b1 || out_imm !== exp_imm[k]) begin
                n_fail++;
                $display("FAIL bp_order%0d got v=%b imm=%h want 1/%h", k, out_valid, out_imm, exp_imm[k]);
            end
        end
        n_cmp++;
        if (acc_cnt !== 16'd3) begin n_fail++; $display("FAIL bp_count got %0d want 3", acc_cnt); end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got v=%b want 0", out_valid); end
    endtask

    task automatic test_err();
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_fmt    = 3'd7;
        in_instr  = $urandom;
        @(negedge clk);
        in_fmt   = 3'd0;
        in_instr = 32'hFFF00093;
        n_cmp++;
        if (out_valid !== 1'b1 || out_imm !== 32'h0 || out_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_fmt7 got v=%b imm=%h e=%b want 1/0/1", out_valid, out_imm, out_err);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_imm !== 32'hFFFFFFFF || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear got v=%b imm=%h e=%b want 1/ffffffff/0", out_valid, out_imm, out_err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_fmt    = 3'd3;
        in_instr  = 32'h123450B7;
        @(negedge clk);
        in_instr = 32'hFFFFF0B7;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || acc_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL rmid_full got rdy=%b v=%b cnt=%0d want 0/1/2", in_ready, out_valid, acc_cnt);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || out_imm !== 32'h0 || out_err !== 1'b0 || acc_cnt !== 16'd0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_reset got v=%b imm=%h e=%b cnt=%0d rdy=%b want 0/0/0/0/0",
                     out_valid, out_imm, out_err, acc_cnt, in_ready);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_release got rdy=%b want 1", in_ready); end
    endtask

    task automatic test_random();
        logic [32:0] q[$];
        logic [15:0] exp_cnt;
        logic [32:0] head;
        int          budget;
        do_reset();
        exp_cnt = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = in_valid ? 32'($urandom) : 'x;
            in_fmt    = in_valid ? 3'($urandom_range(0, 7)) : 'x;
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            n_cmp++;
            if (in_ready !== (q.size() < 2) || out_valid !== (q.size() > 0) || acc_cnt !== exp_cnt) begin
                n_fail++;
                $display("FAIL rand_ctrl c=%0d got rdy=%b v=%b cnt=%0d want %b/%b/%0d",
                         c, in_ready, out_valid, acc_cnt, q.size() < 2, q.size() > 0, exp_cnt);
            end
            if (q.size() > 0) begin
                head = q[0];
                n_cmp++;
                if ({out_err, out_imm} !== head) begin
                    n_fail++;
                    $display("FAIL rand_data c=%0d got e=%b imm=%h want e=%b imm=%h",
                             c, out_err, out_imm, head[32], head[31:0]);
                end
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && q.size() < 2 + (out_ready && q.size() > 0 ? 1 : 0) && in_ready) begin
                q.push_back(ref_model(in_instr, in_fmt));
                exp_cnt++;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        budget    = 0;
        while (q.size() > 0 && budget < 10) begin
            #1;
            n_cmp++;
            if (out_valid !== 1'b1 || {out_err, out_imm} !== q[0]) begin
                n_fail++;
                $display("FAIL rand_drain got v=%b e=%b imm=%h want 1/%b/%h",
                         out_valid, out_err, out_imm, q[0][32], q[0][31:0]);
            end
            void'(q.pop_front());
            @(negedge clk);
            budget++;
        end
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || acc_cnt !== exp_cnt || q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_end got v=%b cnt=%0d left=%0d want 0/%0d/0", out_valid, acc_cnt, q.size(), exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_formats();
        test_backpressure();
        test_err();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
